// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Memory stage of the Lucid64 pipeline. It takes the execute-stage pipeline
// registers and issues loads/stores on a req/gnt/rvalid data-memory port. It
// aligns and sign/zero-extends load data, and stalls the pipeline while an
// access is outstanding. It registers the final rd value for writeback; these
// registers are also the MEM forwarding source for execute.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   squash_i/bubble_i/stall_i  hazard-unit controls for this stage
//   valid_i, alu_res_i, rs2_data_i, rd_data_i, rd_idx_i, rd_wr_en_i,
//   rd_wr_src_1h_i, mem_width_1h_i, mem_rd_i, mem_wr_i, mem_sign_i
//                           execute-stage pipeline registers
//   dmem_*                  data-memory port (req/gnt/rvalid)
//   mem_stall_ao            combinational stall request to the hazard unit
//   valid_o, rd_idx_o, rd_wr_en_o, rd_data_o, misaligned_o
//                           registered writeback / forwarding outputs
//   state_o                 debug view of the access FSM state
//
// Handshake: a request is accepted on a cycle where dmem_req_o and
// dmem_gnt_i are both high. While dmem_req_o is high and not yet granted,
// address, strobes, data and write enable stay constant. Exactly one
// dmem_rvalid_i pulse answers each granted request. At most one request is
// outstanding at any time.
// ---------------------------------------------------------------------------
module memory_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        squash_i,
    input  logic        bubble_i,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [63:0] alu_res_i,
    input  logic [63:0] rs2_data_i,
    input  logic [63:0] rd_data_i,
    input  logic [4:0]  rd_idx_i,
    input  logic        rd_wr_en_i,
    input  logic [2:0]  rd_wr_src_1h_i,
    input  logic [3:0]  mem_width_1h_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic        mem_sign_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [7:0]  dmem_be_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        mem_stall_ao,
    output logic        valid_o,
    output logic [4:0]  rd_idx_o,
    output logic        rd_wr_en_o,
    output logic [63:0] rd_data_o,
    output logic        misaligned_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    logic        squash_seen;
    logic [63:0] hold;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        req_we;

    logic        acc;
    logic [2:0]  off;
    logic        mis;
    logic        go;
    logic        done;
    logic        blocked;
    logic        in_req;

    logic [7:0]  be_mask;
    logic [63:0] wdata_fmt;
    logic [63:0] load_src;
    logic [63:0] load_shift;
    logic [63:0] load_fmt;

    // rd source select is resolved in writeback; this stage only passes data.
    logic        unused_ok;
    assign unused_ok = ^{rd_wr_src_1h_i, mem_width_1h_i[0]};

    assign acc = valid_i & ~squash_i & (mem_rd_i | mem_wr_i);
    assign off = alu_res_i[2:0];

    always_comb begin
        mis = 1'b0;
        if (mem_width_1h_i[1])      mis = off[0];
        else if (mem_width_1h_i[2]) mis = |off[1:0];
        else if (mem_width_1h_i[3]) mis = |off;
    end

    assign go      = acc & ~mis;
    assign in_req  = (state == REQ);
    // REQ and DRAIN always hold the stage, whatever sits in it.
    assign blocked = (state == REQ) | (state == DRAIN);
    assign done    = ~go | ((state == WAIT) & dmem_rvalid_i) | (state == DONE);

    assign mem_stall_ao = (valid_i & ~done) | blocked;

    // Store formatting: strobe mask shifted to the byte offset, data lane
    // replicated so every possible lane carries the operand.
    always_comb begin
        be_mask   = 8'h01;
        wdata_fmt = {8{rs2_data_i[7:0]}};
        if (mem_width_1h_i[1]) begin
            be_mask   = 8'h03;
            wdata_fmt = {4{rs2_data_i[15:0]}};
        end else if (mem_width_1h_i[2]) begin
            be_mask   = 8'h0F;
            wdata_fmt = {2{rs2_data_i[31:0]}};
        end else if (mem_width_1h_i[3]) begin
            be_mask   = 8'hFF;
            wdata_fmt = rs2_data_i;
        end
    end

    // Request is combinational from the pipeline in IDLE; once it has to
    // wait for a grant it is driven from a captured copy so it stays stable
    // even if the instruction is squashed underneath it. Reset gates the
    // request immediately.
    assign dmem_req_o   = rst_ni & (((state == IDLE) & go) | in_req);
    assign dmem_we_o    = in_req ? req_we    : mem_wr_i;
    assign dmem_be_o    = in_req ? req_be    : (be_mask << off);
    assign dmem_addr_o  = in_req ? req_addr  : {alu_res_i[63:3], 3'b000};
    assign dmem_wdata_o = in_req ? req_wdata : wdata_fmt;

    // Load formatting: select response or held data, align, extend.
    assign load_src   = (state == DONE) ? hold : dmem_rdata_i;
    assign load_shift = load_src >> {off, 3'b000};

    always_comb begin
        load_fmt = {{56{mem_sign_i & load_shift[7]}}, load_shift[7:0]};
        if (mem_width_1h_i[1])
            load_fmt = {{48{mem_sign_i & load_shift[15]}}, load_shift[15:0]};
        else if (mem_width_1h_i[2])
            load_fmt = {{32{mem_sign_i & load_shift[31]}}, load_shift[31:0]};
        else if (mem_width_1h_i[3])
            load_fmt = load_shift;
    end

    // Access FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            squash_seen <= 1'b0;
            hold        <= 64'd0;
            req_addr    <= 64'd0;
            req_wdata   <= 64'd0;
            req_be      <= 8'd0;
            req_we      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    squash_seen <= 1'b0;
                    if (go && dmem_gnt_i) begin
                        state <= WAIT;
                    end else if (go) begin
                        state     <= REQ;
                        req_addr  <= {alu_res_i[63:3], 3'b000};
                        req_wdata <= wdata_fmt;
                        req_be    <= be_mask << off;
                        req_we    <= mem_wr_i;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        state       <= (squash_seen || squash_i) ? DRAIN : WAIT;
                        squash_seen <= 1'b0;
                    end else if (squash_i) begin
                        squash_seen <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        // A squashed response has nowhere to go; just drop it.
                        if (squash_i || !stall_i) begin
                            state <= IDLE;
                        end else begin
                            state <= DONE;
                            hold  <= dmem_rdata_i;
                        end
                    end else if (squash_i) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    if (!stall_i) state <= IDLE;
                end
                DRAIN: begin
                    if (dmem_rvalid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o = state;

    // Writeback / forwarding registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o      <= 1'b0;
            rd_idx_o     <= 5'd0;
            rd_wr_en_o   <= 1'b0;
            rd_data_o    <= 64'd0;
            misaligned_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o      <= valid_i & ~squash_i & ~bubble_i & done & ~blocked;
            rd_idx_o     <= rd_idx_i;
            rd_wr_en_o   <= rd_wr_en_i & ~mis;
            rd_data_o    <= mem_rd_i ? load_fmt : rd_data_i;
            misaligned_o <= valid_i & ~squash_i & (mem_rd_i | mem_wr_i) & mis;
        end
    end

endmodule
